// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, winner codes, the eight winning
// lines in scan order, and a cell extractor for the packed 18-bit board.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    O     = 2'b11,
    X     = 2'b10
  } cellStateType;

  localparam logic [1:0] NOWIN = 2'b00;
  localparam logic [1:0] TIE   = 2'b01;
  localparam logic [1:0] P1    = 2'b11;
  localparam logic [1:0] P2    = 2'b10;

  localparam int NUM_CELLS = 9;

  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Zero-extended so any 4-bit index stays in range; cells 9..15 read as EMPTY.
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
    logic [31:0] ext;
    ext = {14'b0, board};
    return ext[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/board_judge_if.sv
// Move write port from the controller and the board/result view back to it.
// The controller is the master; board_judge is the slave.
interface board_judge_if;
  logic        newGame;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic [17:0] gBoard;
  logic        gameIsDone;
  logic [1:0]  winner;
  logic        busy;
  logic        illegalMove;

  modport master (
    output newGame, addr, cellState,
    input  gBoard, gameIsDone, winner, busy, illegalMove
  );

  modport slave (
    input  newGame, addr, cellState,
    output gBoard, gameIsDone, winner, busy, illegalMove
  );
endinterface

// File: rtl/line_select.sv
// Picks the three cells of winning line idx out of the board and flags a win.
// Purely combinational, no latency, no flow control.
module line_select
  import ttt_pkg::*;
(
  input  logic [17:0]     gBoard,
  input  logic [2:0]      idx,
  output logic [2:0][1:0] cells,
  output logic            match
);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cells[k] = cell_at(gBoard, LINES[idx][k]);
    end
  end

  assign match = (cells[0] != EMPTY) && (cells[0] == cells[1]) && (cells[1] == cells[2]);

endmodule

// File: rtl/board_judge.sv
// Board store plus sequential win/tie scan, one line per cycle after each move.
// Result 1..8 cycles after the move edge; writes while busy/done pulse illegalMove.
module board_judge
  import ttt_pkg::*;
(
  input  logic          ph1,
  input  logic          reset,
  board_judge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [17:0]     board_q, board_d;
  logic [2:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic [1:0]      win_q, win_d;
  logic            ill_q, ill_d;

  logic [2:0][1:0] cells;
  logic            match;
  logic            attempt;
  logic            target_empty;
  logic            full;
  logic [1:0]      line_val;

  line_select u_line (
    .gBoard (board_q),
    .idx    (idx_q),
    .cells  (cells),
    .match  (match)
  );

  assign attempt      = (bus.addr <= 4'd8) && ((bus.cellState == O) || (bus.cellState == X));
  assign target_empty = (cell_at(board_q, bus.addr) == EMPTY);
  // All three cells are identical whenever match is set.
  assign line_val     = cells[0] & cells[1] & cells[2];

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_at(board_q, 4'(i)) == EMPTY) full = 1'b0;
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      win_q   <= NOWIN;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      win_q   <= win_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    idx_d   = idx_q;
    done_d  = done_q;
    win_d   = win_q;
    ill_d   = 1'b0;

    if (bus.newGame) begin
      state_d = IDLE;
      board_d = '0;
      idx_d   = '0;
      done_d  = 1'b0;
      win_d   = NOWIN;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (attempt) begin
            if (target_empty) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (bus.addr == 4'(i)) board_d[2*i +: 2] = bus.cellState;
              end
              state_d = SCAN;
              idx_d   = '0;
            end else begin
              ill_d = 1'b1;
            end
          end
        end
        SCAN: begin
          ill_d = attempt;
          if (match) begin
            win_d   = (line_val == O) ? P1 : P2;
            done_d  = 1'b1;
            state_d = DONE;
            idx_d   = '0;
          end else if (idx_q == 3'd7) begin
            idx_d = '0;
            if (full) begin
              win_d   = TIE;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        DONE: begin
          ill_d = attempt;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.gBoard      = board_q;
  assign bus.gameIsDone  = done_q;
  assign bus.winner      = win_q;
  assign bus.busy        = (state_q == SCAN);
  assign bus.illegalMove = ill_q;

endmodule

// File: tb/tb_board_judge.sv
// Directed bench for board_judge: a move table with hand-computed boards and
// results, plus hand-written sequences for reset, latency and newGame overlap.
module tb_board_judge;

  localparam logic [1:0] CE   = 2'b00;
  localparam logic [1:0] CO   = 2'b11;
  localparam logic [1:0] CX   = 2'b10;
  localparam logic [1:0] CBAD = 2'b01;
  localparam logic [3:0] NOP  = 4'hF;

  logic ph1 = 1'b0;
  logic reset;

  board_judge_if bus ();

  board_judge dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ph1 = ~ph1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ng;
    logic [3:0]  addr;
    logic [1:0]  cs;
    int          idle;
    logic [17:0] eb;
    logic        ebusy;
    logic        eill;
    logic [1:0]  ewin;
    logic        edone;
    logic        ebusy2;
  } vec_t;

  vec_t tv[$];

  function automatic logic [17:0] bd(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic vec_t v(input logic ng, input logic [3:0] a, input logic [1:0] cs,
                             input int idle, input logic [17:0] eb, input logic ebusy,
                             input logic eill, input logic [1:0] ewin, input logic edone,
                             input logic ebusy2);
    vec_t r;
    r.ng = ng; r.addr = a; r.cs = cs; r.idle = idle; r.eb = eb; r.ebusy = ebusy;
    r.eill = eill; r.ewin = ewin; r.edone = edone; r.ebusy2 = ebusy2;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  task automatic drive(input logic ng, input logic [3:0] a, input logic [1:0] cs);
    bus.newGame   = ng;
    bus.addr      = a;
    bus.cellState = cs;
  endtask

  // Plays a game from a cleared board and measures cycles from the last move edge.
  task automatic run_game(input string nm, input logic [3:0] a [9], input logic [1:0] c [9],
                          input int n, input int exp_lat, input logic [1:0] exp_win);
    int cnt;
    drive(1'b1, NOP, CE); step();
    for (int i = 0; i < n - 1; i++) begin
      drive(1'b0, a[i], c[i]); step();
      drive(1'b0, NOP, CE);
      repeat (8) step();
    end
    drive(1'b0, a[n-1], c[n-1]); step();
    drive(1'b0, NOP, CE);
    cnt = 0;
    while (!bus.gameIsDone && cnt < 20) begin
      step();
      cnt++;
    end
    chk({nm, "_latency"}, cnt, exp_lat);
    chk({nm, "_winner"}, bus.winner, exp_win);
    chk({nm, "_busy_low"}, bus.busy, 1'b0);
  endtask

  logic [3:0] ga [9];
  logic [1:0] gc [9];

  initial begin
    logic [17:0] b4;
    reset = 1'b1;
    drive(1'b0, NOP, CE);
    #3;
    chk("reset_board", bus.gBoard, 18'h0);
    chk("reset_winner", bus.winner, 2'b00);
    chk("reset_done", bus.gameIsDone, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ill", bus.illegalMove, 1'b0);
    step();
    reset = 1'b0;

    // Row win on line 0, then a write after DONE, then newGame.
    tv.push_back(v(0, 4'd0, CO, 8, bd(CO,CE,CE, CE,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd3, CX, 8, bd(CO,CE,CE, CX,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd1, CO, 8, bd(CO,CO,CE, CX,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd4, CX, 8, bd(CO,CO,CE, CX,CX,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd2, CO, 1, bd(CO,CO,CO, CX,CX,CE, CE,CE,CE), 1, 0, 2'b11, 1, 0));
    tv.push_back(v(0, 4'd5, CX, 1, bd(CO,CO,CO, CX,CX,CE, CE,CE,CE), 0, 1, 2'b11, 1, 0));
    tv.push_back(v(1, NOP,  CE, 1, 18'h0,                            0, 0, 2'b00, 0, 0));
    // Anti-diagonal X win on line 7.
    tv.push_back(v(0, 4'd2, CX, 8, bd(CE,CE,CX, CE,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd0, CO, 8, bd(CO,CE,CX, CE,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd4, CX, 8, bd(CO,CE,CX, CE,CX,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd1, CO, 8, bd(CO,CO,CX, CE,CX,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd6, CX, 8, bd(CO,CO,CX, CE,CX,CE, CX,CE,CE), 1, 0, 2'b10, 1, 0));
    tv.push_back(v(1, NOP,  CE, 1, 18'h0,                            0, 0, 2'b00, 0, 0));
    // Occupied cell, ignored writes, write while busy.
    b4 = bd(CE,CE,CE, CE,CO,CE, CE,CE,CE);
    tv.push_back(v(0, 4'd4, CO,   8, b4, 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd4, CX,   1, b4, 0, 1, 2'b00, 0, 0));
    tv.push_back(v(0, NOP,  CX,   1, b4, 0, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd9, CO,   1, b4, 0, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd0, CE,   1, b4, 0, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd0, CBAD, 1, b4, 0, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd0, CX, 1, bd(CX,CE,CE, CE,CO,CE, CE,CE,CE), 1, 0, 2'b00, 0, 1));
    tv.push_back(v(0, 4'd8, CO, 8, bd(CX,CE,CE, CE,CO,CE, CE,CE,CE), 1, 1, 2'b00, 0, 0));
    tv.push_back(v(1, NOP,  CE, 1, 18'h0,                            0, 0, 2'b00, 0, 0));
    // Tie: O X O / O X X / X O O.
    tv.push_back(v(0, 4'd0, CO, 8, bd(CO,CE,CE, CE,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd1, CX, 8, bd(CO,CX,CE, CE,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd2, CO, 8, bd(CO,CX,CO, CE,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd3, CO, 8, bd(CO,CX,CO, CO,CE,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd4, CX, 8, bd(CO,CX,CO, CO,CX,CE, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd5, CX, 8, bd(CO,CX,CO, CO,CX,CX, CE,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd6, CX, 8, bd(CO,CX,CO, CO,CX,CX, CX,CE,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd7, CO, 8, bd(CO,CX,CO, CO,CX,CX, CX,CO,CE), 1, 0, 2'b00, 0, 0));
    tv.push_back(v(0, 4'd8, CO, 8, bd(CO,CX,CO, CO,CX,CX, CX,CO,CO), 1, 0, 2'b01, 1, 0));

    foreach (tv[i]) begin
      drive(tv[i].ng, tv[i].addr, tv[i].cs);
      step();
      chk($sformatf("v%0d_board", i), bus.gBoard, tv[i].eb);
      chk($sformatf("v%0d_busy", i), bus.busy, tv[i].ebusy);
      chk($sformatf("v%0d_ill", i), bus.illegalMove, tv[i].eill);
      drive(1'b0, NOP, CE);
      repeat (tv[i].idle) step();
      chk($sformatf("v%0d_winner", i), bus.winner, tv[i].ewin);
      chk($sformatf("v%0d_done", i), bus.gameIsDone, tv[i].edone);
      chk($sformatf("v%0d_busy2", i), bus.busy, tv[i].ebusy2);
      chk($sformatf("v%0d_ill_end", i), bus.illegalMove, 1'b0);
    end

    // Asynchronous reset mid-cycle while holding a tie result.
    #2 reset = 1'b1;
    #1;
    chk("async_board", bus.gBoard, 18'h0);
    chk("async_winner", bus.winner, 2'b00);
    chk("async_done", bus.gameIsDone, 1'b0);
    chk("async_busy", bus.busy, 1'b0);
    @(negedge ph1);
    reset = 1'b0;

    // Exact result latencies measured from the final write edge.
    ga = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2, NOP, NOP, NOP, NOP};
    gc = '{CO, CX, CO, CX, CO, CE, CE, CE, CE};
    run_game("row", ga, gc, 5, 1, 2'b11);
    ga = '{4'd2, 4'd0, 4'd4, 4'd1, 4'd6, NOP, NOP, NOP, NOP};
    gc = '{CX, CO, CX, CO, CX, CE, CE, CE, CE};
    run_game("diag", ga, gc, 5, 8, 2'b10);
    ga = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    gc = '{CO, CX, CO, CO, CX, CX, CX, CO, CO};
    run_game("tie", ga, gc, 9, 8, 2'b01);

    // newGame together with a write in the middle of a scan.
    drive(1'b1, NOP, CE); step();
    drive(1'b0, 4'd0, CX); step();
    chk("ngscan_busy_before", bus.busy, 1'b1);
    drive(1'b1, 4'd5, CO); step();
    chk("ngscan_board", bus.gBoard, 18'h0);
    chk("ngscan_busy", bus.busy, 1'b0);
    chk("ngscan_ill", bus.illegalMove, 1'b0);
    drive(1'b0, NOP, CE); step();
    chk("ngscan_board2", bus.gBoard, 18'h0);
    chk("ngscan_busy2", bus.busy, 1'b0);
    chk("ngscan_winner", bus.winner, 2'b00);
    chk("ngscan_done", bus.gameIsDone, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
